// File: rtl/product_accumulator_pkg.sv
// mult_pkg: shared types and helpers for the sequential multiplier slice.
//
// Contents:
//   mult_state_t  - sequencing states of the accumulation stage
//   prod_width()  - product width for a given operand width (2 * Word_Length)
package mult_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, DONE} mult_state_t;

  function automatic int prod_width(input int word_length);
    return 2 * word_length;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: bus between the accumulation stage and its
// neighbours (shifter stages upstream, product consumer downstream).
//
// Signals:
//   start                 request a new multiplication (seen only while Ready)
//   Multiplier_Bit        current multiplier LSB from the right-shift stage
//   Shifted_Multiplicand  Data_Output of Left_Shifter, 2*Word_Length bits
//   Multiplier_Zero       remaining multiplier bits all zero
//                         (only when MULT_EARLY_DONE_EN is defined)
//   Load_enable           1 loads both shifters, 0 shifts them
//   Product               accumulated product, 2*Word_Length bits
//   Ready                 stage idle and able to accept start
//   Done                  one-cycle pulse, Product is final
//
// Modports:
//   slave   - the accumulation stage itself
//   master  - the surrounding datapath / controller driving it
interface product_accumulator_if
  import mult_pkg::*;
#(
  parameter int Word_Length = 8
);

  localparam int PW = prod_width(Word_Length);

  logic          start;
  logic          Multiplier_Bit;
  logic [PW-1:0] Shifted_Multiplicand;
`ifdef MULT_EARLY_DONE_EN
  logic          Multiplier_Zero;
`endif
  logic          Load_enable;
  logic [PW-1:0] Product;
  logic          Ready;
  logic          Done;

`ifdef MULT_EARLY_DONE_EN
  modport slave (
    input  start, Multiplier_Bit, Shifted_Multiplicand, Multiplier_Zero,
    output Load_enable, Product, Ready, Done
  );

  modport master (
    output start, Multiplier_Bit, Shifted_Multiplicand, Multiplier_Zero,
    input  Load_enable, Product, Ready, Done
  );
`else
  modport slave (
    input  start, Multiplier_Bit, Shifted_Multiplicand,
    output Load_enable, Product, Ready, Done
  );

  modport master (
    output start, Multiplier_Bit, Shifted_Multiplicand,
    input  Load_enable, Product, Ready, Done
  );
`endif

endinterface

// File: rtl/product_accumulator_step_counter.sv
// step_counter: counts steps 0 .. Word_Length-1 and flags the last one.
// Shared between the accumulation stage and the right-shift stage.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-low reset (count -> 0)
//   clear     synchronous clear to 0 (has priority over enable)
//   enable    advance the count by one
//   terminal  count equals Word_Length-1
module step_counter #(
  parameter int Word_Length = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (Word_Length > 1) ? $clog2(Word_Length) : 1;
  localparam logic [CW-1:0] LAST = CW'(Word_Length - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: accumulation and sequencing stage of the sequential
// multiplier. Strobes the shifters to load, then for Word_Length cycles adds
// the shifted multiplicand into the product register whenever the current
// multiplier bit is 1, and finally pulses Done.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low reset
//   bus    product_accumulator_if.slave (see interface for signal list)
//
// Parameter Word_Length must match the Word_Length of the connected interface.
//
// Optional feature, macro MULT_EARLY_DONE_EN: when defined, the stage leaves
// ACCUM as soon as the right-shift stage reports Multiplier_Zero, so latency
// tracks the position of the highest set multiplier bit.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int Word_Length = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  product_accumulator_if.slave  bus
);

  localparam int PW = prod_width(Word_Length);

  mult_state_t   state;
  logic [PW-1:0] acc;
  logic          load_q;
  logic          ready_q;
  logic          done_q;

  logic          cnt_clear;
  logic          cnt_en;
  logic          cnt_last;
  logic          finish_accum;

  // The step counter is restarted in LOAD so it reads 0 on the first ACCUM cycle.
  assign cnt_clear = (state == LOAD);
  assign cnt_en    = (state == ACCUM);

  step_counter #(
    .Word_Length (Word_Length)
  ) u_step_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_last)
  );

`ifdef MULT_EARLY_DONE_EN
  // No set bits remain, so further ACCUM cycles could only add zero.
  assign finish_accum = cnt_last || bus.Multiplier_Zero;
`else
  assign finish_accum = cnt_last;
`endif

  // Outputs are registered alongside the state so each one is valid in the
  // cycle its state is entered, with no input-to-output path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      load_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= LOAD;
            load_q  <= 1'b0 | 1'b1;
            ready_q <= 1'b0;
          end
        end
        LOAD: begin
          state <= ACCUM;
          acc   <= '0;
        end
        ACCUM: begin
          if (bus.Multiplier_Bit) begin
            acc <= acc + bus.Shifted_Multiplicand;
          end
          if (finish_accum) begin
            state   <= DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.start) begin
            state   <= LOAD;
            load_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Load_enable = load_q;
  assign bus.Product     = acc;
  assign bus.Ready       = ready_q;
  assign bus.Done        = done_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: self-checking bench for product_accumulator with
// Word_Length = 8. Models the two shifter stages around the DUT and compares
// results against plain arithmetic (a*b) and the expected cycle latency.
// Build with MULT_EARLY_DONE_EN defined to exercise the early-done variant.
module tb_product_accumulator;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic clk;
  logic reset;

  int checks;
  int errors;

  logic [W-1:0]  mcand_val;
  logic [W-1:0]  mplier_val;
  logic [PW-1:0] sh_mcand;
  logic [W-1:0]  sh_mplier;

  product_accumulator_if #(.Word_Length(W)) bus ();

  product_accumulator #(.Word_Length(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Left_Shifter / right-shift stage stand-ins: load on Load_enable, else shift.
  always @(posedge clk) begin
    if (bus.Load_enable) begin
      sh_mcand  <= {{W{1'b0}}, mcand_val};
      sh_mplier <= mplier_val;
    end else begin
      sh_mcand  <= sh_mcand << 1;
      sh_mplier <= sh_mplier >> 1;
    end
  end

  assign bus.Shifted_Multiplicand = sh_mcand;
  assign bus.Multiplier_Bit       = sh_mplier[0];
`ifdef MULT_EARLY_DONE_EN
  assign bus.Multiplier_Zero      = ((sh_mplier >> 1) == '0);
`endif

  // Cycles from the start edge to the Done cycle.
  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MULT_EARLY_DONE_EN
    if (b == '0) return 3;
    return $clog2(int'(b) + 1) + 2;
`else
    return W + 2;
`endif
  endfunction

  // Called at a negedge; raises start for one edge and waits for Done.
  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic le_first,
                         output logic [PW-1:0] prod);
    mcand_val = a;
    mplier_val = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    le_first = bus.Load_enable;
    lat = 1;
    while (bus.Done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    prod = bus.Product;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Product !== '0) begin
      errors++;
      $display("[TB] FAIL reset_product got %0h expected 0", bus.Product);
    end
    checks++;
    if (bus.Load_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_load_enable got %b expected 0", bus.Load_enable);
    end
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done got %b expected 0", bus.Done);
    end
    checks++;
    if (bus.Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b expected 1", bus.Ready);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0]  a_list [3] = '{8'd13, 8'd255, 8'hAA};
    logic [W-1:0]  b_list [3] = '{8'd11, 8'd255, 8'd0};
    int            lat;
    logic          le;
    logic [PW-1:0] prod;
    logic [PW-1:0] expected;
    for (int i = 0; i < 3; i++) begin
      do_mult(a_list[i], b_list[i], lat, le, prod);
      expected = PW'(a_list[i]) * PW'(b_list[i]);
      checks++;
      if (le !== 1'b1) begin
        errors++;
        $display("[TB] FAIL directed_load_enable[%0d] got %b expected 1", i, le);
      end
      checks++;
      if (lat != exp_latency(b_list[i])) begin
        errors++;
        $display("[TB] FAIL directed_latency[%0d] got %0d expected %0d", i, lat, exp_latency(b_list[i]));
      end
      checks++;
      if (prod !== expected) begin
        errors++;
        $display("[TB] FAIL directed_product[%0d] got %0d expected %0d", i, prod, expected);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            lat;
    logic          le;
    logic [PW-1:0] prod;
    logic [PW-1:0] expected;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      expected = PW'(a) * PW'(b);
      do_mult(a, b, lat, le, prod);
      checks++;
      if (prod !== expected || lat != exp_latency(b)) begin
        errors++;
        $display("[TB] FAIL random[%0d] %0d*%0d got %0d lat %0d expected %0d lat %0d",
                 i, a, b, prod, lat, expected, exp_latency(b));
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.Product !== expected || bus.Done !== 1'b0 || bus.Ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL random_hold[%0d] got prod %0d done %b ready %b expected prod %0d done 0 ready 1",
                 i, bus.Product, bus.Done, bus.Ready, expected);
      end
    end
  endtask

  task automatic test_start_ignored();
    int            done_count;
    logic [PW-1:0] prod;
    mcand_val = 8'd13;
    mplier_val = 8'd11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_count = 0;
    prod = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Done === 1'b1) begin
        done_count++;
        prod = bus.Product;
      end
      @(negedge clk);
    end
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("[TB] FAIL ignored_start_done_count got %0d expected 1", done_count);
    end
    checks++;
    if (prod !== 16'd143) begin
      errors++;
      $display("[TB] FAIL ignored_start_product got %0d expected 143", prod);
    end
  endtask

  task automatic test_back_to_back();
    int            lat1;
    int            lat2;
    logic          le1;
    logic          le2;
    logic [PW-1:0] p1;
    logic [PW-1:0] p2;
    do_mult(8'd5, 8'd9, lat1, le1, p1);
    do_mult(8'd7, 8'd3, lat2, le2, p2);
    checks++;
    if (p1 !== 16'd45 || lat1 != exp_latency(8'd9)) begin
      errors++;
      $display("[TB] FAIL b2b_first got %0d lat %0d expected 45 lat %0d", p1, lat1, exp_latency(8'd9));
    end
    checks++;
    if (le2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_load_after_done got %b expected 1", le2);
    end
    checks++;
    if (p2 !== 16'd21 || lat2 != exp_latency(8'd3)) begin
      errors++;
      $display("[TB] FAIL b2b_second got %0d lat %0d expected 21 lat %0d", p2, lat2, exp_latency(8'd3));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_accum();
    int            done_count;
    int            lat;
    logic          le;
    logic [PW-1:0] prod;
    mcand_val = 8'd200;
    mplier_val = 8'd255;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.Product !== '0 || bus.Ready !== 1'b1 || bus.Done !== 1'b0 || bus.Load_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset got prod %0d ready %b done %b load %b expected 0 1 0 0",
               bus.Product, bus.Ready, bus.Done, bus.Load_enable);
    end
    reset = 1'b1;
    done_count = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) done_count++;
    end
    checks++;
    if (done_count != 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_no_done got %0d expected 0", done_count);
    end
    do_mult(8'd7, 8'd6, lat, le, prod);
    checks++;
    if (prod !== 16'd42) begin
      errors++;
      $display("[TB] FAIL mid_reset_recovery got %0d expected 42", prod);
    end
    @(negedge clk);
  endtask

`ifdef MULT_EARLY_DONE_EN
  task automatic test_early_done();
    logic [W-1:0]  a;
    int            lat;
    logic          le;
    logic [PW-1:0] prod;
    a = W'($urandom_range(1, 255));
    do_mult(a, 8'd3, lat, le, prod);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("[TB] FAIL early_done_latency got %0d expected 4", lat);
    end
    checks++;
    if (prod !== PW'(a) * 3) begin
      errors++;
      $display("[TB] FAIL early_done_product got %0d expected %0d", prod, PW'(a) * 3);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    mcand_val = '0;
    mplier_val = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_accum();
`ifdef MULT_EARLY_DONE_EN
    test_early_done();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
